mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single MAR/RAM port between the instruction-fetch requester (F) and the decoder data-access requester (D).
//  Round-robin arbitration; sequences MAR write then RAM read/write via the existing req/ack strobes; returns read data.
//  Sits between fetch/id_fsm logic and the memory blocks; a watchdog flags a memory block that never acks.
// PARAMETERS
//  PA_ADDR_WIDTH  32'd16  address width of MAR
//  PA_DATA_WIDTH  32'd32  RAM data width
//  PA_TIMEOUT     32'd16  max cycles waiting for any single ack before abort (>=2)
// PORTS
//  clk            in   1     clock, rising edge
//  rst_b          in   1     asynchronous active-low reset
//  f_req          in   1     fetch read request (level, 4-phase)
//  f_addr         in   AW    fetch address
//  f_ack          out  1     fetch done; f_rdata valid while high
//  f_rdata        out  DW    fetch read data
//  d_req          in   1     data request (level, 4-phase)
//  d_we           in   1     1=write, 0=read
//  d_addr         in   AW    data address
//  d_wdata        in   DW    data write value
//  d_ack          out  1     data done; d_rdata valid while high (reads)
//  d_rdata        out  DW    data read value
//  mar_wr         out  1     MAR load strobe, held until mar_wr_ack
//  mar_addr       out  AW    address to MAR
//  mar_wr_ack     in   1     MAR load complete
//  ram_oe         out  1     RAM read strobe, held until ram_oe_ack
//  ram_oe_ack     in   1     read data valid on ram_rdata
//  ram_rdata      in   DW    RAM read data
//  ram_wr         out  1     RAM write strobe, held until ram_wr_ack
//  ram_wdata      out  DW    RAM write data
//  ram_wr_ack     in   1     write complete
//  busy           out  1     state != IDLE
//  timeout_err    out  1     sticky watchdog flag
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, last_grant=D (F wins first tie), counter 0.
//  - States: IDLE -> MAR -> (RD | WR) -> RESP -> IDLE.
//  - IDLE: if exactly one req high, grant it; both high, grant the one not in last_grant. On grant latch owner,
//    addr, we (F always read), wdata; update last_grant; go MAR with mar_wr=1, mar_addr=latched addr.
//  - MAR: hold mar_wr until mar_wr_ack sampled high; then mar_wr=0, go RD (ram_oe=1) or WR (ram_wr=1, ram_wdata).
//  - RD: on ram_oe_ack capture ram_rdata into owner's rdata, ram_oe=0, go RESP with owner ack=1.
//  - WR: on ram_wr_ack ram_wr=0, go RESP with owner ack=1.
//  - RESP: hold ack while owner req high; when req sampled low drop ack, go IDLE. New grant no earlier than next cycle.
//  - Latency with same-cycle acks: req sampled at edge N -> mar_wr N+1 -> ram strobe N+2 -> ack N+3.
//  - Requester inputs ignored after grant; req dropped mid-transaction: transaction completes, ack pulses 1 cycle.
//  - Non-owner req held during a transaction waits; served next after RESP (round-robin => no starvation).
//  - Watchdog: counter clears on every state entry, counts in MAR/RD/WR; reaching PA_TIMEOUT-1 without ack:
//    drop strobe, set timeout_err (sticky until reset), rdata=0, go RESP (owner still gets ack).
//  - rdata registers retain value until next read completion for that owner.
//  - Reset asserted mid-transaction: strobes and acks clear immediately; no partial completion after release.
// TESTING
//  - F read addr 0x0010, immediate acks, ram_rdata=0xDEADBEEF -> mar_addr=0x0010, f_ack at N+3, f_rdata=0xDEADBEEF.
//  - D write addr 0x0100 data 0x12345678, ram_wr_ack delayed 3 cycles -> ram_wr held 3 cycles, d_ack 1 cycle later.
//  - f_req,d_req both high from reset, held -> grants F,D,F,D alternate; busy low exactly 1 cycle between.
//  - mar_wr_ack never asserted, PA_TIMEOUT=16 -> mar_wr drops after 15 cycles, timeout_err=1, ack with rdata=0.
//  - rst_b low during RD state -> ram_oe,f_ack,busy 0 immediately; after release, held f_req restarts from MAR.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one MAR/RAM port between the fetch (F) and data (D) requesters.
// Each grant loads the MAR, then strobes a RAM read or write; a watchdog aborts stalled handshakes.
module mem_arbiter #(
  parameter int unsigned PA_ADDR_WIDTH = 32'd16,
  parameter int unsigned PA_DATA_WIDTH = 32'd32,
  parameter int unsigned PA_TIMEOUT    = 32'd16
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     f_req,
  input  logic [PA_ADDR_WIDTH-1:0] f_addr,
  output logic                     f_ack,
  output logic [PA_DATA_WIDTH-1:0] f_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [PA_ADDR_WIDTH-1:0] d_addr,
  input  logic [PA_DATA_WIDTH-1:0] d_wdata,
  output logic                     d_ack,
  output logic [PA_DATA_WIDTH-1:0] d_rdata,
  output logic                     mar_wr,
  output logic [PA_ADDR_WIDTH-1:0] mar_addr,
  input  logic                     mar_wr_ack,
  output logic                     ram_oe,
  input  logic                     ram_oe_ack,
  input  logic [PA_DATA_WIDTH-1:0] ram_rdata,
  output logic                     ram_wr,
  output logic [PA_DATA_WIDTH-1:0] ram_wdata,
  input  logic                     ram_wr_ack,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned CW = (PA_TIMEOUT > 2) ? $clog2(PA_TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(PA_TIMEOUT - 2);

  typedef enum logic [2:0] {S_IDLE, S_MAR, S_RD, S_WR, S_RESP} state_t;

  state_t                   state, state_n;
  logic                     owner_d, owner_d_n;
  logic                     last_d, last_d_n;
  logic                     we_q, we_n;
  logic [PA_DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [CW-1:0]            wd_cnt, wd_n;
  logic                     f_ack_n, d_ack_n, mar_wr_n, ram_oe_n, ram_wr_n, busy_n, err_n;
  logic [PA_DATA_WIDTH-1:0] f_rdata_n, d_rdata_n, ram_wdata_n;
  logic [PA_ADDR_WIDTH-1:0] mar_addr_n;
  logic                     grant_d, finish, abort, wd_expire, owner_req;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      last_d      <= 1'b1;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wd_cnt      <= '0;
      f_ack       <= 1'b0;
      d_ack       <= 1'b0;
      f_rdata     <= '0;
      d_rdata     <= '0;
      mar_wr      <= 1'b0;
      mar_addr    <= '0;
      ram_oe      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_wdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      owner_d     <= owner_d_n;
      last_d      <= last_d_n;
      we_q        <= we_n;
      wdata_q     <= wdata_n;
      wd_cnt      <= wd_n;
      f_ack       <= f_ack_n;
      d_ack       <= d_ack_n;
      f_rdata     <= f_rdata_n;
      d_rdata     <= d_rdata_n;
      mar_wr      <= mar_wr_n;
      mar_addr    <= mar_addr_n;
      ram_oe      <= ram_oe_n;
      ram_wr      <= ram_wr_n;
      ram_wdata   <= ram_wdata_n;
      busy        <= busy_n;
      timeout_err <= err_n;
    end
  end

  // Watchdog expires on the edge where the count would reach PA_TIMEOUT-1 without an ack.
  always_comb begin
    state_n     = state;
    owner_d_n   = owner_d;
    last_d_n    = last_d;
    we_n        = we_q;
    wdata_n     = wdata_q;
    wd_n        = wd_cnt;
    f_ack_n     = f_ack;
    d_ack_n     = d_ack;
    f_rdata_n   = f_rdata;
    d_rdata_n   = d_rdata;
    mar_wr_n    = mar_wr;
    mar_addr_n  = mar_addr;
    ram_oe_n    = ram_oe;
    ram_wr_n    = ram_wr;
    ram_wdata_n = ram_wdata;
    err_n       = timeout_err;
    grant_d     = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    wd_expire   = (wd_cnt == WD_LAST);
    owner_req   = owner_d ? d_req : f_req;

    unique case (state)
      S_IDLE: begin
        if (f_req || d_req) begin
          grant_d    = d_req && (!f_req || !last_d);
          owner_d_n  = grant_d;
          last_d_n   = grant_d;
          we_n       = grant_d && d_we;
          wdata_n    = d_wdata;
          mar_addr_n = grant_d ? d_addr : f_addr;
          mar_wr_n   = 1'b1;
          wd_n       = '0;
          state_n    = S_MAR;
        end
      end
      S_MAR: begin
        if (mar_wr_ack) begin
          mar_wr_n = 1'b0;
          wd_n     = '0;
          if (we_q) begin
            ram_wr_n    = 1'b1;
            ram_wdata_n = wdata_q;
            state_n     = S_WR;
          end else begin
            ram_oe_n = 1'b1;
            state_n  = S_RD;
          end
        end else if (wd_expire) begin
          mar_wr_n = 1'b0;
          abort    = 1'b1;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      S_RD: begin
        if (ram_oe_ack) begin
          ram_oe_n = 1'b0;
          finish   = 1'b1;
          if (owner_d) d_rdata_n = ram_rdata;
          else         f_rdata_n = ram_rdata;
        end else if (wd_expire) begin
          ram_oe_n = 1'b0;
          abort    = 1'b1;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      S_WR: begin
        if (ram_wr_ack) begin
          ram_wr_n = 1'b0;
          finish   = 1'b1;
        end else if (wd_expire) begin
          ram_wr_n = 1'b0;
          abort    = 1'b1;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (!owner_req) begin
          f_ack_n = 1'b0;
          d_ack_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // An aborted transaction still acknowledges its owner, with zeroed read data.
    if (abort) begin
      finish = 1'b1;
      err_n  = 1'b1;
      if (!we_q) begin
        if (owner_d) d_rdata_n = '0;
        else         f_rdata_n = '0;
      end
    end

    if (finish) begin
      state_n = S_RESP;
      wd_n    = '0;
      if (owner_d) d_ack_n = 1'b1;
      else         f_ack_n = 1'b1;
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule
